// File: rtl/mult_acc_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mult_acc_stage
//
// Burst accumulator placed behind an 8x8 approximate multiplier. A burst is
// opened with start/len in IDLE. The stage then accepts len unsigned 16-bit
// products over a valid/ready handshake and adds each one into an unsigned
// accumulator that saturates at its maximum value. The result is held with
// sum_valid until downstream takes it with sum_ready.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle burst request, honoured only in IDLE
//   len         number of products in the burst (0 = immediate empty result)
//   prod_valid  upstream product present
//   prod        16-bit unsigned product
//   prod_ready  stage accepts prod this cycle (high exactly in ACC)
//   sum_valid   accumulated result present (high exactly in HOLD)
//   sum         accumulator register, ACC_W bits unsigned
//   sum_ready   downstream accepts sum this cycle
//   sat         sticky saturation flag for the current / last burst
//   busy        state is not IDLE
// -----------------------------------------------------------------------------
module mult_acc_stage #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_valid,
  input  logic [15:0]      prod,
  output logic             prod_ready,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum,
  input  logic             sum_ready,
  output logic             sat,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [ACC_W:0]   add_res;

  // Saturating add of a zero-extended product. The MSB of the result is the
  // overflow flag; on overflow the value part is clamped to all ones, so an
  // already saturated accumulator stays at its maximum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [15:0]      p);
    logic [ACC_W:0] full;
    full = {1'b0, a} + {{(ACC_W + 1 - 16){1'b0}}, p};
    if (full[ACC_W]) begin
      sat_add = {1'b1, ACC_MAX};
    end else begin
      sat_add = full;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    add_res = sat_add(acc_q, prod);
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = len;
          // An empty burst skips ACC and presents a zero result at once.
          state_d = (len == '0) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (prod_valid) begin
          acc_d = add_res[ACC_W-1:0];
          sat_d = sat_q | add_res[ACC_W];
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // start is deliberately not looked at here, even on the release edge.
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  // Moore decodes of the state register; sum/sat come straight from registers.
  assign prod_ready = (state_q == ACC);
  assign sum_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign sum        = acc_q;
  assign sat        = sat_q;

endmodule

// File: doc/mult_acc_stage.md
MULT_ACC_STAGE -- requirements
Module: mult_acc_stage

Interface
REQ-001 Parameter ACC_W, default 24: accumulator and result width in bits; legal range 17..32.
REQ-002 Parameter LEN_W, default 8: width of the burst-length field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of products in the burst; sampled with start.
REQ-007 prod_valid  input  1  upstream 8x8 multiplier product present.
REQ-008 prod  input  16  unsigned product from the upstream 8x8 approximate multiplier (its R output).
REQ-009 prod_ready  output  1  stage accepts prod this cycle.
REQ-010 sum_valid  output  1  accumulated result present.
REQ-011 sum  output  ACC_W  unsigned accumulated result.
REQ-012 sum_ready  input  1  downstream accepts sum this cycle.
REQ-013 sat  output  1  result saturated during the current or last burst.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and HOLD.
REQ-016 In IDLE with start=1 and len!=0, the stage SHALL latch len into the remaining-count register, clear the accumulator and sat, and enter ACC on the next edge.
REQ-017 In IDLE with start=1 and len=0, the stage SHALL clear the accumulator and sat and enter HOLD directly, producing sum=0.
REQ-018 start SHALL be ignored in ACC and HOLD, with no effect on len, the count or the accumulator.
REQ-019 prod_ready SHALL equal 1 exactly when the state is ACC (Moore output, registered-state decode).
REQ-020 A product is accepted on an edge where prod_valid=1 and prod_ready=1; no other edge SHALL modify the accumulator in ACC.
REQ-021 Each accepted product SHALL be zero-extended to ACC_W bits and added to the accumulator.
REQ-022 If the true sum exceeds 2^ACC_W-1, the accumulator SHALL hold 2^ACC_W-1 and sat SHALL set. sat stays set (sticky) until the next accepted start.
REQ-023 Once saturated, further accepted products SHALL keep the accumulator at 2^ACC_W-1.
REQ-024 The remaining count SHALL decrement by 1 per accepted product. On the edge accepting the product that brings it to 0, the FSM SHALL enter HOLD.
REQ-025 Latency: sum_valid SHALL assert in the cycle immediately after the last product is accepted, with sum already including that product.
REQ-026 In HOLD, sum_valid=1 and sum, sat SHALL remain stable until a cycle with sum_ready=1. On that edge the FSM SHALL return to IDLE.
REQ-027 In IDLE and ACC, sum_valid SHALL be 0. sum SHALL always drive the accumulator register directly.
REQ-028 A start asserted in the same cycle as the HOLD->IDLE transfer SHALL be ignored. A new burst requires start in a cycle where the state is IDLE.
REQ-029 prod_valid with no prod_ready (IDLE, HOLD) SHALL be a no-op. Upstream holds data per valid/ready rules.
REQ-030 The maximum burst is 2^LEN_W-1 products.

Reset
REQ-031 Asserting rst_n=0 at any time, including mid-burst or in HOLD, SHALL immediately force state=IDLE, accumulator=0, count=0 and sat=0.
REQ-032 While rst_n=0, prod_ready=0, sum_valid=0, sum=0, sat=0 and busy=0.
REQ-033 After rst_n deasserts, the first start SHALL be honoured at the first rising edge on which it is sampled in IDLE.

Verification
REQ-034 Stimulus: start with len=3; products 0x0010, 0x0020, 0x0030 on consecutive cycles; sum_ready=1. Required: sum_valid in the cycle after the third accept, sum=0x000060, sat=0, back in IDLE one cycle later.
REQ-035 Stimulus: len=2; prod_valid gapped (valid, 3 idle cycles, valid) with products 0xFFFF and 0x0001. Required: sum=0x010000, with only 2 accepts counted.
REQ-036 Stimulus: ACC_W=17, len=3, products all 0xFFFF. Required: sum=0x1FFFF and sat=1. A following burst with len=1 and product 5 gives sum=5 and sat=0.
REQ-037 Stimulus: len=1, product 7, sum_ready held 0 for 5 cycles with start pulsed and prod_valid=1 throughout. Required: sum=7 stable, prod_ready=0, start ignored; exit to IDLE on the sum_ready edge.
REQ-038 Stimulus: rst_n pulsed low asynchronously mid-burst (after 2 of 4 accepts). Required: outputs clear immediately, with no sum_valid. A new burst then accumulates from 0.
REQ-039 Stimulus: start with len=0. Required: sum_valid on the next cycle with sum=0, sat=0, and prod_ready never asserted.
